// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-master arbiter for a single shared DataMem port.
//             A round-robin arbiter with an optional bounded lock. Each
//             accepted transaction runs IDLE -> ISSUE (-> RESP for reads).
//  Ports    : clock / clrn        rising-edge clock, async active-low reset
//             m0_* / m1_*         master request, fields, grant and response
//             mem_*               shared DataMem port (mem_rdata arrives one
//                                 cycle after mem_re)
//             busy / owner        FSM not idle / index of the last grant
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 16
) (
   input  logic              clock,
   input  logic              clrn,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [2:0]        m0_op,
   input  logic              m0_lock,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [2:0]        m1_op,
   input  logic              m1_lock,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_op,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   localparam int              CNT_W      = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t            state, next_state;
   logic [1:0]        rst_sync;
   logic              arb_en;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [2:0]        lat_op;
   logic              lat_lock;
   logic [CNT_W-1:0]  lock_cnt;

   logic              grant, win;
   logic              req_owner, req_other, lock_hold;
   logic              sel_we, sel_lock;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [2:0]        sel_op;

   // Reset release is re-timed to the clock; arbitration only starts once
   // the synchronised release has propagated, and gnt stays low meanwhile.
   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) rst_sync <= 2'b00;
      else       rst_sync <= {rst_sync[0], 1'b1};
   end
   assign arb_en = rst_sync[1];

   assign req_owner = owner ? m1_req : m0_req;
   assign req_other = owner ? m0_req : m1_req;
   // The owner keeps the port only while its last accepted transaction was
   // locked, it is still asking, and the starvation bound is not reached.
   assign lock_hold = lat_lock & req_owner & (lock_cnt < LOCK_MAX_C);

   always_comb begin
      next_state = state;
      grant      = 1'b0;
      win        = owner;
      case (state)
         IDLE: begin
            if (arb_en && (m0_req || m1_req)) begin
               grant      = 1'b1;
               next_state = ISSUE;
               if (lock_hold)      win = owner;
               else if (req_other) win = ~owner;
               else                win = owner;
            end
         end
         ISSUE:   next_state = lat_we ? IDLE : RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign m0_gnt    = grant & ~win;
   assign m1_gnt    = grant &  win;
   assign sel_we    = win ? m1_we    : m0_we;
   assign sel_addr  = win ? m1_addr  : m0_addr;
   assign sel_wdata = win ? m1_wdata : m0_wdata;
   assign sel_op    = win ? m1_op    : m0_op;
   assign sel_lock  = win ? m1_lock  : m0_lock;

   // Address/data/op come straight from the latched fields, so they hold
   // their last values between transactions; only the strobes are gated.
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign mem_op    = lat_op;
   assign mem_we    = (state == ISSUE) &  lat_we;
   assign mem_re    = (state == ISSUE) & ~lat_we;
   assign busy      = (state != IDLE);

   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         state     <= IDLE;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_op    <= '0;
         lat_lock  <= 1'b0;
         lock_cnt  <= '0;
         owner     <= 1'b1;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         state     <= next_state;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;

         if (grant) begin
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            lat_op    <= sel_op;
            lat_lock  <= sel_lock;
            owner     <= win;
            // Only a lock-won grant against a waiting master is counted.
            if ((win != owner) || !sel_lock)
               lock_cnt <= '0;
            else if (lock_hold && req_other)
               lock_cnt <= lock_cnt + CNT_W'(1);
         end else if ((state == IDLE) && lat_lock && !req_owner) begin
            // Locked owner walked away: release the lock.
            lat_lock <= 1'b0;
            lock_cnt <= '0;
         end

         if (state == RESP) begin
            if (owner) begin
               m1_rdata  <= mem_rdata;
               m1_rvalid <= 1'b1;
            end else begin
               m0_rdata  <= mem_rdata;
               m0_rvalid <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Scoreboard bench for dmem_arbiter with a behavioural DataMem.
//             Stimulus pushes expected grants, writes and read data into
//             queues; a monitor pops and compares when the DUT presents them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

   logic        clock = 1'b0;
   logic        clrn  = 1'b0;
   logic        m0_req = 0, m0_we = 0, m0_lock = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0;
   logic [2:0]  m0_op = 0;
   logic        m1_req = 0, m1_we = 0, m1_lock = 0;
   logic [31:0] m1_addr = 0, m1_wdata = 0;
   logic [2:0]  m1_op = 0;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 0;
   logic [2:0]  mem_op;
   logic        mem_we, mem_re, busy, owner;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(16)) dut (
      .clock(clock), .clrn(clrn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_op(m0_op), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_op(m1_op), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_op(mem_op),
      .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  op;
   } wr_t;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          acc0     = 0;
   int          acc1     = 0;
   int          we_cnt   = 0;
   int          exp_gnt_q[$];
   logic [31:0] exp_rd0[$];
   logic [31:0] exp_rd1[$];
   wr_t         exp_wr0[$];
   wr_t         exp_wr1[$];
   wr_t         mon_w;

   // DataMem model: unwritten words read back as A5000000 | word index.
   logic [31:0] dmem[int];
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (mem_we) dmem[int'(mem_addr[9:2])] = mem_wdata;
      if (mem_re)
         mem_rdata <= dmem.exists(int'(mem_addr[9:2])) ? dmem[int'(mem_addr[9:2])]
                                                       : (32'hA500_0000 | 32'(mem_addr[9:2]));
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic bad(input string name);
      n_checks++;
      $display("FAIL %s: event present, none expected (t=%0t)", name, $time);
   endtask

   // Monitor: compares everything the DUT presents against the queues.
   always @(negedge clock) begin
      if (clrn) begin
         if (m0_rvalid) begin
            if (exp_rd0.size() == 0) bad("m0_rvalid_unexpected");
            else begin
               chk("m0_rdata", m0_rdata, exp_rd0.pop_front());
               chk("m0_rd_latency", 32'(cyc - acc0), 32'd3);
            end
         end
         if (m1_rvalid) begin
            if (exp_rd1.size() == 0) bad("m1_rvalid_unexpected");
            else begin
               chk("m1_rdata", m1_rdata, exp_rd1.pop_front());
               chk("m1_rd_latency", 32'(cyc - acc1), 32'd3);
            end
         end
         if (mem_we || mem_re) begin
            chk("strobe_in_busy", 32'(busy), 32'd1);
            chk("strobe_exclusive", 32'(mem_we & mem_re), 32'd0);
         end
         if (mem_we) begin
            we_cnt++;
            if ((owner ? exp_wr1.size() : exp_wr0.size()) == 0) bad("mem_we_unexpected");
            else begin
               mon_w = owner ? exp_wr1.pop_front() : exp_wr0.pop_front();
               chk("mem_addr", mem_addr, mon_w.a);
               chk("mem_wdata", mem_wdata, mon_w.d);
               chk("mem_op", 32'(mem_op), 32'(mon_w.op));
            end
         end
         if (m0_gnt || m1_gnt) begin
            chk("single_gnt", 32'(m0_gnt & m1_gnt), 32'd0);
            if (m1_gnt) acc1 = cyc; else acc0 = cyc;
            if (exp_gnt_q.size() == 0) bad("gnt_unexpected");
            else chk("gnt_order", 32'(m1_gnt), 32'(exp_gnt_q.pop_front()));
         end
      end
   end

   // One transaction for master m: present fields, hold req until gnt.
   task automatic do_txn(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] op,
                         input logic lock, input logic [31:0] exp_rd);
      bit ok = 0;
      wr_t w;
      w.a = addr; w.d = wdata; w.op = op;
      if (m == 0) begin
         m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_op = op; m0_lock = lock; m0_req = 1;
         if (we) exp_wr0.push_back(w); else exp_rd0.push_back(exp_rd);
      end else begin
         m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_op = op; m1_lock = lock; m1_req = 1;
         if (we) exp_wr1.push_back(w); else exp_rd1.push_back(exp_rd);
      end
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if ((m == 0) ? m0_gnt : m1_gnt) begin ok = 1; break; end
      end
      if (!ok) begin
         n_checks++;
         $display("FAIL gnt_timeout: master %0d got no gnt, required one within 300 cycles", m);
      end
      @(posedge clock); #1;
      if (m == 0) m0_req = 0; else m1_req = 0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int we_before;
      // Reset values
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_owner", 32'(owner), 32'd1);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_strobes", 32'({mem_we, mem_re}), 32'd0);
      chk("rst_m0_rdata", m0_rdata, 32'd0);
      clrn = 1'b1;
      repeat (2) @(posedge clock); #1;

      // Contested reads: master 0 first because owner resets to 1.
      exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
      fork
         do_txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hA500_0004);
         do_txn(1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 32'hA500_0008);
      join
      chk("owner_after_rr", 32'(owner), 32'd1);
      repeat (4) @(posedge clock); #1;

      // Write then read back through the other master.
      we_before = we_cnt;
      exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
      do_txn(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'h0);
      do_txn(1, 1'b0, 32'h40, 32'h0, 3'b010, 1'b0, 32'hDEAD_BEEF);
      repeat (4) @(posedge clock); #1;
      chk("single_we_cycle", 32'(we_cnt - we_before), 32'd1);

      // Lock bound: 17 m0 grants, one m1 grant, then m0 resumes.
      for (int i = 0; i < 17; i++) exp_gnt_q.push_back(0);
      exp_gnt_q.push_back(1);
      for (int i = 0; i < 3; i++) exp_gnt_q.push_back(0);
      fork
         for (int i = 0; i < 20; i++)
            do_txn(0, 1'b1, 32'h100 + 32'(i * 4), 32'h5A00 + 32'(i), 3'b010, 1'b1, 32'h0);
         do_txn(1, 1'b1, 32'h200, 32'h0000_0B0B, 3'b010, 1'b0, 32'h0);
      join

      // Locked owner drops req: m1 granted at once, count cleared.
      exp_gnt_q.push_back(1);
      do_txn(1, 1'b1, 32'h204, 32'h0000_1111, 3'b001, 1'b0, 32'h0);
      chk("lock_cnt_cleared", 32'(dut.lock_cnt), 32'd0);
      repeat (3) @(posedge clock); #1;

      // Reset during the RESP cycle of an m1 read aborts it.
      exp_gnt_q.push_back(1);
      do_txn(1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 32'h0);
      @(posedge clock); #1;
      clrn = 1'b0;
      exp_rd1.delete();
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_strobes", 32'({mem_we, mem_re}), 32'd0);
      chk("abort_owner", 32'(owner), 32'd1);
      chk("abort_mem_addr", mem_addr, 32'd0);
      chk("abort_m0_rdata", m0_rdata, 32'd0);
      chk("abort_m1_rdata", m1_rdata, 32'd0);
      chk("abort_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
      @(negedge clock);
      clrn = 1'b1;
      repeat (3) @(posedge clock); #1;
      exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
      fork
         do_txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hA500_0004);
         do_txn(1, 1'b0, 32'h40, 32'h0, 3'b010, 1'b0, 32'hDEAD_BEEF);
      join
      repeat (10) @(posedge clock); #1;

      chk("pending_gnt", 32'(exp_gnt_q.size()), 32'd0);
      chk("pending_rd0", 32'(exp_rd0.size()), 32'd0);
      chk("pending_rd1", 32'(exp_rd1.size()), 32'd0);
      chk("pending_wr", 32'(exp_wr0.size() + exp_wr1.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
